// File: rtl/alu_result_collector_if.sv
// ---------------------------------------------------------------------------
// alu_result_collector_if
//   Frame stream from the collector FIFO to its sink. The producer (master)
//   presents the head frame with out_valid; the sink (slave) accepts it by
//   raising out_ready. A frame moves on every edge where both are high.
//
//   out_data   16  head frame {or,and,sub,add}, add in [3:0]; 0 when empty
//   out_valid   1  a frame is available
//   out_ready   1  sink accepts the head frame this cycle
// ---------------------------------------------------------------------------
interface alu_result_collector_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
//   Sits behind the counter-sequenced 3-bit ALU, which produces one 4-bit
//   result per clock in the order add, sub, and, or. This block keeps its own
//   2-bit phase counter in lock-step with the ALU (same clock, same reset
//   release), gathers the four results of each round into a 16-bit frame and
//   queues the frames in a first-word-fall-through FIFO for the sink.
//
// Parameters
//   DEPTH   FIFO depth in frames (power of 2, >= 2)
//   LW      width of level; 2**LW must exceed DEPTH
//
// Ports
//   clk        in    rising-edge clock
//   reset      in    asynchronous reset, active low
//   y_in       in    ALU result for the current phase
//   sink       if    frame stream (master side): out_data/out_valid/out_ready
//   level      out   frames stored, 0..DEPTH
//   overflow   out   sticky flag, a completed frame was dropped
//   clr_ovf    in    clears overflow on the next edge (a drop wins)
//   drop_cnt   out   dropped-frame count, saturates at 255
//   phase      out   current slot index 0..3 (add, sub, and, or)
// ---------------------------------------------------------------------------
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             y_in,
  alu_result_collector_if.master sink,
  output logic [LW-1:0]          level,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [7:0]             drop_cnt,
  output logic [1:0]             phase
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Phase counter and the three slots that hold add/sub/and until the or
  // result arrives.
  logic [1:0]        phase_reg;
  logic [3:0]        slot_reg [3];

  // FIFO storage. No reset on the array: emptiness is tracked by level_reg
  // and the output is masked to zero when nothing is stored.
  logic [15:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;

  logic              overflow_reg;
  logic [7:0]        drop_cnt_reg;

  logic              full;
  logic              empty;
  logic              frame_done;
  logic              push;
  logic              pop;
  logic              drop;
  logic [15:0]       frame_word;

  assign full       = (level_reg == DEPTH_L);
  assign empty      = (level_reg == '0);
  assign frame_done = (phase_reg == 2'd3);
  assign pop        = !empty && sink.out_ready;
  // A full FIFO still takes the new frame when the head leaves on the same
  // edge; only a full FIFO with no pop loses the frame.
  assign push       = frame_done && (!full || pop);
  assign drop       = frame_done && full && !pop;

  // The or result is taken straight from y_in in phase 3, so the frame is
  // pushed on the same edge the last sample is presented.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pack
      assign frame_word[gi*4 +: 4] = slot_reg[gi];
    end
  endgenerate
  assign frame_word[15:12] = y_in;

  // -------------------------------------------------------------------------
  // Phase tracking and slot capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        slot_reg[i] <= 4'd0;
      end
    end else begin
      phase_reg <= phase_reg + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (phase_reg == 2'(i)) begin
          slot_reg[i] <= y_in;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= frame_word;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Drop bookkeeping: sticky flag (set beats clear) and saturating counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
      if (drop && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Head frame falls through combinationally from storage; it only
  // changes on a pop or when the first frame lands in an empty FIFO.
  // -------------------------------------------------------------------------
  assign sink.out_valid = !empty;
  assign sink.out_data  = empty ? 16'h0000 : mem[rd_ptr_reg];
  assign level          = level_reg;
  assign overflow       = overflow_reg;
  assign drop_cnt       = drop_cnt_reg;
  assign phase          = phase_reg;

endmodule
